// File: rtl/comparator_exerciser.sv
// Self-test sequencer for a 1-bit magnitude comparator: sweeps {a,b} over 00..11 and counts bad {L,E,G} responses.
// Optional first-failure capture ports are built when COMPARATOR_EXERCISER_FAIL_CAPTURE_EN is defined.
module comparator_exerciser #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned PASSES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       L,
    input  logic       E,
    input  logic       G,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [1:0] vec_idx
`ifdef COMPARATOR_EXERCISER_FAIL_CAPTURE_EN
    ,
    output logic       fail_valid,
    output logic [1:0] fail_vec,
    output logic [2:0] fail_leg
`endif
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [7:0] PASSES_LAST = 8'(PASSES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_a;
    logic        r_b;
    logic        r_done;
    logic        r_pass;
    logic [7:0]  r_err;
    logic [1:0]  r_vec;
    logic [7:0]  r_pass_cnt;
    logic [3:0]  r_settle;
    logic        w_busy;
    logic [2:0]  w_exp;
    logic        w_mismatch;
    logic        w_last_vec;
`ifdef COMPARATOR_EXERCISER_FAIL_CAPTURE_EN
    logic        r_fail_valid;
    logic [1:0]  r_fail_vec;
    logic [2:0]  r_fail_leg;
`endif

    // Any deviation from the one-hot ideal, including multi-hot or all-zero, is a single error.
    assign w_exp      = {~r_a & r_b, ~(r_a ^ r_b), r_a & ~r_b};
    assign w_mismatch = ({L, E, G} != w_exp);
    assign w_last_vec = (r_vec == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_DRIVE;
            S_DRIVE: w_next = S_WAIT;
            S_WAIT:  if (r_settle == SETTLE_LAST) w_next = S_CHECK;
            S_CHECK: begin
                if (w_last_vec && (r_pass_cnt == PASSES_LAST)) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_DRIVE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            S_DRIVE, S_WAIT, S_CHECK: w_busy = 1'b1;
            default:                  w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err      <= '0;
            r_vec      <= '0;
            r_pass_cnt <= '0;
            r_settle   <= '0;
`ifdef COMPARATOR_EXERCISER_FAIL_CAPTURE_EN
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
            r_fail_leg   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_a <= 1'b0;
                    r_b <= 1'b0;
                    if (start) begin
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_err      <= '0;
                        r_vec      <= '0;
                        r_pass_cnt <= '0;
`ifdef COMPARATOR_EXERCISER_FAIL_CAPTURE_EN
                        r_fail_valid <= 1'b0;
                        r_fail_vec   <= '0;
                        r_fail_leg   <= '0;
`endif
                    end
                end
                S_DRIVE: begin
                    r_a      <= r_vec[1];
                    r_b      <= r_vec[0];
                    r_settle <= '0;
                end
                S_WAIT: begin
                    r_settle <= r_settle + 4'd1;
                end
                S_CHECK: begin
                    if (w_mismatch && (r_err != '1)) begin
                        r_err <= r_err + 8'd1;
                    end
`ifdef COMPARATOR_EXERCISER_FAIL_CAPTURE_EN
                    if (w_mismatch && !r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_fail_vec   <= {r_a, r_b};
                        r_fail_leg   <= {L, E, G};
                    end
`endif
                    r_vec <= r_vec + 2'd1;
                    if (w_last_vec) begin
                        r_pass_cnt <= r_pass_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    r_pass <= (r_err == '0);
                    r_a    <= 1'b0;
                    r_b    <= 1'b0;
                end
                default: begin
                    r_a <= 1'b0;
                    r_b <= 1'b0;
                end
            endcase
        end
    end

    assign a         = r_a;
    assign b         = r_b;
    assign busy      = w_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign vec_idx   = r_vec;
`ifdef COMPARATOR_EXERCISER_FAIL_CAPTURE_EN
    assign fail_valid = r_fail_valid;
    assign fail_vec   = r_fail_vec;
    assign fail_leg   = r_fail_leg;
`endif

endmodule

// File: tb/tb_comparator_exerciser.sv
// Scoreboard bench for comparator_exerciser: a table-driven comparator model answers {a,b}; a monitor checks results.
module tb_comparator_exerciser;

    localparam int S  = 2;
    localparam int P  = 1;
    localparam int T  = 4 * P * (S + 2) + 1;
    localparam int P2 = 100;
    localparam int T2 = 4 * P2 * (S + 2) + 1;

    typedef struct {
        int unsigned start_cyc;
        int unsigned lat;
        logic [7:0]  err;
        logic        pass;
        logic        fv;
        logic [1:0]  fvec;
        logic [2:0]  fleg;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic a, b, busy, done, pass;
    logic [7:0] err_count;
    logic [1:0] vec_idx;
    logic L, E, G;
    logic a2, b2, busy2, done2, pass2;
    logic [7:0] err2;
    logic [1:0] vec2;
    logic zero = 1'b0;
`ifdef COMPARATOR_EXERCISER_FAIL_CAPTURE_EN
    logic fail_valid, fail_valid2;
    logic [1:0] fail_vec, fail_vec2;
    logic [2:0] fail_leg, fail_leg2;
`endif

    logic [2:0] resp_tbl [4];
    exp_t sb[$];
    exp_t mon_e;
    int unsigned cyc = 0;
    int unsigned trace_start = 0;
    bit trace_active = 1'b0;
    logic prev_done = 1'b0;
    int checks = 0;
    int failures = 0;

    assign {L, E, G} = resp_tbl[{a, b}];

    comparator_exerciser #(.SETTLE(S), .PASSES(P)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .L(L), .E(E), .G(G), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .vec_idx(vec_idx)
`ifdef COMPARATOR_EXERCISER_FAIL_CAPTURE_EN
        , .fail_valid(fail_valid), .fail_vec(fail_vec), .fail_leg(fail_leg)
`endif
    );

    comparator_exerciser #(.SETTLE(S), .PASSES(P2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
        .L(zero), .E(zero), .G(zero), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .vec_idx(vec2)
`ifdef COMPARATOR_EXERCISER_FAIL_CAPTURE_EN
        , .fail_valid(fail_valid2), .fail_vec(fail_vec2), .fail_leg(fail_leg2)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ideal comparator answer for vector v, where v = {a,b}.
    function automatic logic [2:0] ideal_resp(input int v);
        int aa, bb;
        aa = v / 2;
        bb = v % 2;
        return {aa < bb, aa == bb, aa > bb};
    endfunction

    function automatic exp_t predict(input int unsigned sc);
        exp_t e;
        int errs;
        errs = 0;
        e.fv = 1'b0;
        e.fvec = '0;
        e.fleg = '0;
        for (int p = 0; p < P; p++) begin
            for (int v = 0; v < 4; v++) begin
                if (resp_tbl[v] !== ideal_resp(v)) begin
                    errs++;
                    if (!e.fv) begin
                        e.fv = 1'b1;
                        e.fvec = 2'(v);
                        e.fleg = resp_tbl[v];
                    end
                end
            end
        end
        e.start_cyc = sc;
        e.lat = T;
        e.err = (errs > 255) ? 8'd255 : 8'(errs);
        e.pass = (errs == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        int n, g, m;
        if (done === 1'b1 && prev_done !== 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", done, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_latency", cyc - mon_e.start_cyc, mon_e.lat);
                chk("err_count", err_count, mon_e.err);
                chk("pass", pass, mon_e.pass);
`ifdef COMPARATOR_EXERCISER_FAIL_CAPTURE_EN
                chk("fail_valid", fail_valid, mon_e.fv);
                if (mon_e.fv) begin
                    chk("fail_vec", fail_vec, mon_e.fvec);
                    chk("fail_leg", fail_leg, mon_e.fleg);
                end
`endif
            end
        end
        prev_done = done;
        if (trace_active) begin
            n = int'(cyc) - int'(trace_start);
            if (n >= 0 && n <= T) begin
                g = (n >= 1 && n <= T - 1) ? ((n - 1) / (S + 2)) % 4 : 0;
                m = (n < T - 1) ? n : T - 1;
                chk("trace_a", a, g / 2);
                chk("trace_b", b, g % 2);
                chk("trace_busy", busy, (n <= T - 2) ? 1 : 0);
                chk("trace_vec_idx", vec_idx, (m / (S + 2)) % 4);
            end
        end
    end

    task automatic issue();
        start = 1'b1;
        sb.push_back(predict(cyc + 1));
        trace_start = cyc + 1;
        trace_active = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", done, 1);
    endtask

    task automatic run_one();
        issue();
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(4 * T);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_a"}, a, 0);
        chk({tag, "_b"}, b, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err"}, err_count, 0);
        chk({tag, "_vec"}, vec_idx, 0);
`ifdef COMPARATOR_EXERCISER_FAIL_CAPTURE_EN
        chk({tag, "_fail_valid"}, fail_valid, 0);
`endif
    endtask

    task automatic set_ideal();
        for (int v = 0; v < 4; v++) resp_tbl[v] = ideal_resp(v);
    endtask

    initial begin
        int unsigned c0;
        bit seen;
        set_ideal();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_idle("reset");
        chk("reset_busy2", busy2, 0);
        chk("reset_done2", done2, 0);
        rst = 1'b0;
        @(posedge clk); #2;

        // Ideal comparator, L stuck low, E/G forced high, all-zero responses.
        set_ideal();
        run_one();
        set_ideal();
        resp_tbl[1] = resp_tbl[1] & 3'b011;
        run_one();
        for (int v = 0; v < 4; v++) resp_tbl[v] = ideal_resp(v) | 3'b011;
        run_one();
        for (int v = 0; v < 4; v++) resp_tbl[v] = 3'b000;
        run_one();

        // Start pulsed mid-run must not disturb the sweep.
        set_ideal();
        issue();
        @(posedge clk); #2;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(4 * T);
        repeat (2) @(posedge clk);
        #2;

        // Start held high: ignored while busy, then relaunches straight from IDLE.
        resp_tbl[2] = 3'b111;
        issue();
        @(posedge clk); #2;
        wait_done(4 * T);
        issue();
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(4 * T);
        repeat (2) @(posedge clk);
        #2;

        // Reset while vector 10 is settling.
        set_ideal();
        issue();
        @(posedge clk); #2;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        chk("pre_reset_a", a, 1);
        chk("pre_reset_b", b, 0);
        chk("pre_reset_busy", busy, 1);
        rst = 1'b1;
        trace_active = 1'b0;
        sb.delete();
        @(posedge clk); #2;
        check_idle("abort");
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("abort_no_done", done, 0);

        // Reset wins over a simultaneous start.
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        start = 1'b0;
        check_idle("rst_over_start");
        @(posedge clk); #2;
        chk("rst_over_start_stays_idle", busy, 0);

        set_ideal();
        run_one();

        for (int r = 0; r < 10; r++) begin
            for (int v = 0; v < 4; v++) begin
                resp_tbl[v] = ($urandom_range(0, 1) == 1) ? ideal_resp(v) : 3'($urandom);
            end
            run_one();
        end
        set_ideal();
        run_one();

        // Long sweep with a dead comparator: error count must saturate.
        start2 = 1'b1;
        c0 = cyc + 1;
        @(posedge clk); #2;
        start2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < T2 + 50; i++) begin
            @(posedge clk); #2;
            if (done2 === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("sat_done_timeout", done2, 1);
        chk("sat_latency", cyc - c0, T2);
        chk("sat_err_count", err2, 255);
        chk("sat_pass", pass2, 0);
        chk("sat_busy", busy2, 0);
`ifdef COMPARATOR_EXERCISER_FAIL_CAPTURE_EN
        chk("sat_fail_valid", fail_valid2, 1);
        chk("sat_fail_vec", fail_vec2, 0);
        chk("sat_fail_leg", fail_leg2, 0);
`endif

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
